inst_rom_arbiter: RTL and testbench

Shares the single-port instruction ROM between two requesters: the CPU instruction-fetch port (I) and a data/debug read port (D). It is used, for example, for loads from the code region or for debug memory reads. The block sits between the CPU and the ROM at SOPC level. It drives the ROM chip-enable and address, and routes the 1-cycle-latency read data back to the requester it was fetched for. Arbitration is round-robin, with an out-of-range check on the D port.

---
 rtl/inst_rom_arbiter_if.sv | 48 ++++
 rtl/inst_rom_arbiter.sv | 143 ++++++++++++++
 tb/tb_inst_rom_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : inst_rom_arbiter_if
// Description : Bundle of the two read-request ports (instruction fetch I,
//               data/debug D) and the single-port ROM side of the
//               instruction-ROM arbiter.
//               slave  - view taken by the arbiter
//               master - view taken by the requesters / ROM (or a bench)
//               Ports:
//                 i_req_i/i_addr_i   fetch request and byte address
//                 i_ack_o/i_rdata_o  fetch acknowledge pulse and data
//                 d_req_i/d_addr_i   data request and byte address
//                 d_ack_o/d_rdata_o  data acknowledge pulse and data
//                 d_err_o            data address out of ROM range (with ack)
//                 rom_ce_o/rom_addr_o ROM chip enable and byte address
//                 rom_data_i         ROM read data
// Revision    : 1.0 - initial release
//============================================================================
interface inst_rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_ack_o;
    logic [DATA_W-1:0] i_rdata_o;
    logic              d_req_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_err_o;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;

    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_addr_i, rom_data_i,
        output i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, d_err_o,
               rom_ce_o, rom_addr_o
    );

    modport master (
        output i_req_i, i_addr_i, d_req_i, d_addr_i, rom_data_i,
        input  i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, d_err_o,
               rom_ce_o, rom_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/inst_rom_arbiter.sv
`default_nettype none
//============================================================================
// Module      : inst_rom_arbiter
// Description : Round-robin arbiter sharing one single-port instruction ROM
//               between the CPU fetch port (I) and a data/debug port (D).
//               Pipeline: grant decided in cycle N, ROM slot (rom_ce_o /
//               rom_addr_o) in N+1, registered ack + data in N+2.
//               D addresses beyond the ROM depth are acked with d_err_o and
//               never reach the ROM.
//               Ports:
//                 clk  system clock, rising edge
//                 rst  asynchronous reset, active low
//                 bus  inst_rom_arbiter_if.slave (requests, acks, ROM side)
// Revision    : 1.0 - initial release
//============================================================================
module inst_rom_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ROM_WORDS_LOG2 = 17
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_arbiter_if.slave bus
);

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    // First byte-address bit above the ROM word index.
    localparam int c_IDX_TOP = ROM_WORDS_LOG2 + 2;

    src_e              last_grant_q, last_grant_d;
    logic              slot_vld_q,   slot_vld_d;
    src_e              slot_src_q,   slot_src_d;
    logic              slot_err_q,   slot_err_d;
    logic              rom_ce_q,     rom_ce_d;
    logic [ADDR_W-1:0] rom_addr_q,   rom_addr_d;
    logic              i_ack_q,      i_ack_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic              d_ack_q,      d_ack_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              d_err_q,      d_err_d;

    logic              d_oor;
    logic              i_elig;
    logic              d_elig;
    logic              gnt_vld;
    src_e              gnt_src;
    logic              gnt_err;

    // D is out of range when any address bit above the word index is set.
    // A ROM that spans the whole address space can never be exceeded.
    generate
        if (c_IDX_TOP < ADDR_W) begin : g_range_chk
            assign d_oor = |bus.d_addr_i[ADDR_W-1:c_IDX_TOP];
        end else begin : g_no_range_chk
            assign d_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        last_grant_d = last_grant_q;
        gnt_src      = SRC_I;

        // A requester whose access occupies the ROM slot this cycle is
        // masked; its request line still shows the address being served.
        // In its ack cycle it is eligible again and presents its next one.
        i_elig  = bus.i_req_i && !(slot_vld_q && (slot_src_q == SRC_I));
        d_elig  = bus.d_req_i && !(slot_vld_q && (slot_src_q == SRC_D));
        gnt_vld = i_elig || d_elig;

        if (i_elig && d_elig) begin
            gnt_src = (last_grant_q == SRC_I) ? SRC_D : SRC_I;
        end else if (d_elig) begin
            gnt_src = SRC_D;
        end

        if (gnt_vld) begin
            last_grant_d = gnt_src;
        end

        // An out-of-range D access consumes its slot but never enables the ROM.
        gnt_err    = gnt_vld && (gnt_src == SRC_D) && d_oor;
        slot_vld_d = gnt_vld;
        slot_src_d = gnt_src;
        slot_err_d = gnt_err;
        rom_ce_d   = gnt_vld && !gnt_err;
        rom_addr_d = rom_addr_q;
        if (rom_ce_d) begin
            rom_addr_d = (gnt_src == SRC_D) ? bus.d_addr_i : bus.i_addr_i;
        end

        // Response stage: capture ROM data at the end of the slot cycle.
        i_ack_d   = slot_vld_q && (slot_src_q == SRC_I);
        d_ack_d   = slot_vld_q && (slot_src_q == SRC_D);
        d_err_d   = d_ack_d && slot_err_q;
        i_rdata_d = i_ack_d ? bus.rom_data_i : i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (d_ack_d) begin
            d_rdata_d = slot_err_q ? '0 : bus.rom_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= SRC_D;
            slot_vld_q   <= 1'b0;
            slot_src_q   <= SRC_I;
            slot_err_q   <= 1'b0;
            rom_ce_q     <= 1'b0;
            rom_addr_q   <= '0;
            i_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            slot_vld_q   <= slot_vld_d;
            slot_src_q   <= slot_src_d;
            slot_err_q   <= slot_err_d;
            rom_ce_q     <= rom_ce_d;
            rom_addr_q   <= rom_addr_d;
            i_ack_q      <= i_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_ack_q      <= d_ack_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    assign bus.rom_ce_o   = rom_ce_q;
    assign bus.rom_addr_o = rom_addr_q;
    assign bus.i_ack_o    = i_ack_q;
    assign bus.i_rdata_o  = i_rdata_q;
    assign bus.d_ack_o    = d_ack_q;
    assign bus.d_rdata_o  = d_rdata_q;
    assign bus.d_err_o    = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_inst_rom_arbiter
// Description : Self-checking bench for inst_rom_arbiter. Directed scenarios
//               plus a randomized run against a cycle-event reference model.
//               The ROM is modelled as a fixed function of the address; when
//               rom_ce_o is low the ROM data lines carry random noise.
// Revision    : 1.0 - initial release
//============================================================================
module tb_inst_rom_arbiter;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int ROM_WORDS_LOG2 = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] noise;
    int                checks   = 0;
    int                failures = 0;

    inst_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_rom_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ROM_WORDS_LOG2(ROM_WORDS_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (w == 32'd1) return 32'h3401_1100;
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.rom_data_i = bus.rom_ce_o ? rom_fn(bus.rom_addr_o) : noise;

    function automatic logic [99:0] outs();
        return {bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o, bus.i_rdata_o,
                bus.d_ack_o, bus.d_rdata_o, bus.d_err_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        noise = $urandom;
    endtask

    task automatic drive_idle();
        bus.i_req_i  = 1'b0;
        bus.d_req_i  = 1'b0;
        bus.i_addr_i = $urandom;
        bus.d_addr_i = $urandom;
    endtask

    task automatic drive_random();
        bus.i_req_i  = 1'($urandom_range(0, 1));
        bus.d_req_i  = 1'($urandom_range(0, 1));
        bus.i_addr_i = $urandom;
        bus.d_addr_i = $urandom;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drive_idle();
        tick();
        tick();
        rst = 1'b1;
    endtask

    //------------------------------------------------------------------------
    task automatic test_reset();
        drive_random();
        tick();
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if (outs() !== '0)
            $display("FAIL reset_async: got %h expected %h", outs(), 100'h0);
        for (int k = 0; k < 3; k++) begin
            drive_random();
            tick();
            checks++;
            if (outs() !== '0)
                $display("FAIL reset_held: got %h expected %h", outs(), 100'h0);
        end
        rst = 1'b1;
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (outs() !== '0) begin
                failures++;
                $display("FAIL idle_after_reset: got %h expected %h", outs(), 100'h0);
            end
        end
    endtask

    //------------------------------------------------------------------------
    task automatic test_single_fetch();
        apply_reset();
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h4;
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o} !== {1'b1, 32'h4, 1'b0}) begin
            failures++;
            $display("FAIL fetch_slot: got ce=%b addr=%h ack=%b expected ce=1 addr=4 ack=0",
                     bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o);
        end
        tick();
        checks++;
        if ({bus.i_ack_o, bus.i_rdata_o, bus.rom_ce_o} !== {1'b1, 32'h3401_1100, 1'b0}) begin
            failures++;
            $display("FAIL fetch_ack: got ack=%b data=%h ce=%b expected ack=1 data=34011100 ce=0",
                     bus.i_ack_o, bus.i_rdata_o, bus.rom_ce_o);
        end
        bus.i_addr_i = 32'h8;
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o} !== {1'b1, 32'h8, 1'b0}) begin
            failures++;
            $display("FAIL fetch2_slot: got ce=%b addr=%h ack=%b expected ce=1 addr=8 ack=0",
                     bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o);
        end
        tick();
        checks++;
        if ({bus.i_ack_o, bus.i_rdata_o} !== {1'b1, rom_fn(32'h8)}) begin
            failures++;
            $display("FAIL fetch2_ack: got ack=%b data=%h expected ack=1 data=%h",
                     bus.i_ack_o, bus.i_rdata_o, rom_fn(32'h8));
        end
        bus.i_req_i = 1'b0;
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o, bus.i_rdata_o}
                !== {1'b0, 32'h8, 1'b0, rom_fn(32'h8)}) begin
            failures++;
            $display("FAIL fetch_hold: got ce=%b addr=%h ack=%b data=%h expected ce=0 addr=8 ack=0 data=%h",
                     bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o, bus.i_rdata_o, rom_fn(32'h8));
        end
    endtask

    //------------------------------------------------------------------------
    task automatic test_tie();
        logic [31:0] ea;
        logic        e_i, e_d;
        apply_reset();
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h0;
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h10;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ea = (c % 2 == 1) ? 32'(32'h100 * ((c - 1) / 2))
                              : 32'(32'h10 + 32'h100 * ((c - 2) / 2));
            checks++;
            if ({bus.rom_ce_o, bus.rom_addr_o} !== {1'b1, ea}) begin
                failures++;
                $display("FAIL tie_slot c=%0d: got ce=%b addr=%h expected ce=1 addr=%h",
                         c, bus.rom_ce_o, bus.rom_addr_o, ea);
            end
            e_i = (c % 2 == 0);
            e_d = (c % 2 == 1) && (c >= 3);
            checks++;
            if ({bus.i_ack_o, bus.d_ack_o} !== {e_i, e_d}) begin
                failures++;
                $display("FAIL tie_acks c=%0d: got i=%b d=%b expected i=%b d=%b",
                         c, bus.i_ack_o, bus.d_ack_o, e_i, e_d);
            end
            if (e_i) begin
                ea = 32'(32'h100 * ((c - 2) / 2));
                checks++;
                if (bus.i_rdata_o !== rom_fn(ea)) begin
                    failures++;
                    $display("FAIL tie_idata c=%0d: got %h expected %h", c, bus.i_rdata_o, rom_fn(ea));
                end
                bus.i_addr_i = 32'(32'h100 * (c / 2));
            end
            if (e_d) begin
                ea = 32'(32'h10 + 32'h100 * ((c - 3) / 2));
                checks++;
                if (bus.d_rdata_o !== rom_fn(ea)) begin
                    failures++;
                    $display("FAIL tie_ddata c=%0d: got %h expected %h", c, bus.d_rdata_o, rom_fn(ea));
                end
                bus.d_addr_i = 32'(32'h10 + 32'h100 * ((c - 1) / 2));
            end
        end
        drive_idle();
    endtask

    //------------------------------------------------------------------------
    task automatic test_out_of_range();
        apply_reset();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h80;
        tick();
        tick();
        checks++;
        if ({bus.d_ack_o, bus.d_err_o, bus.d_rdata_o} !== {1'b1, 1'b0, rom_fn(32'h80)}) begin
            failures++;
            $display("FAIL oor_inrange: got ack=%b err=%b data=%h expected 1 0 %h",
                     bus.d_ack_o, bus.d_err_o, bus.d_rdata_o, rom_fn(32'h80));
        end
        bus.d_addr_i = 32'h0008_0000;
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h40;
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o} !== {1'b1, 32'h40}) begin
            failures++;
            $display("FAIL oor_islot: got ce=%b addr=%h expected ce=1 addr=40",
                     bus.rom_ce_o, bus.rom_addr_o);
        end
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o, bus.i_rdata_o, bus.d_ack_o}
                !== {1'b0, 32'h40, 1'b1, rom_fn(32'h40), 1'b0}) begin
            failures++;
            $display("FAIL oor_dslot: got ce=%b addr=%h iack=%b idata=%h dack=%b expected 0 40 1 %h 0",
                     bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o, bus.i_rdata_o, bus.d_ack_o,
                     rom_fn(32'h40));
        end
        bus.i_req_i = 1'b0;
        tick();
        checks++;
        if ({bus.d_ack_o, bus.d_err_o, bus.d_rdata_o, bus.rom_ce_o}
                !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL oor_ack: got ack=%b err=%b data=%h ce=%b expected 1 1 0 0",
                     bus.d_ack_o, bus.d_err_o, bus.d_rdata_o, bus.rom_ce_o);
        end
        bus.d_addr_i = 32'hFFFF_FFF0;
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o, bus.d_ack_o, bus.d_err_o}
                !== {1'b0, 32'h40, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL oor2_slot: got ce=%b addr=%h ack=%b err=%b expected 0 40 0 0",
                     bus.rom_ce_o, bus.rom_addr_o, bus.d_ack_o, bus.d_err_o);
        end
        tick();
        checks++;
        if ({bus.d_ack_o, bus.d_err_o, bus.d_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL oor2_ack: got ack=%b err=%b data=%h expected 1 1 0",
                     bus.d_ack_o, bus.d_err_o, bus.d_rdata_o);
        end
        bus.d_req_i = 1'b0;
        tick();
        checks++;
        if ({bus.d_ack_o, bus.d_err_o, bus.d_rdata_o, bus.rom_ce_o} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL oor_idle: got ack=%b err=%b data=%h ce=%b expected 0 0 0 0",
                     bus.d_ack_o, bus.d_err_o, bus.d_rdata_o, bus.rom_ce_o);
        end
    endtask

    //------------------------------------------------------------------------
    task automatic test_reset_mid();
        apply_reset();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h20;
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o} !== {1'b1, 32'h20}) begin
            failures++;
            $display("FAIL rmid_slot: got ce=%b addr=%h expected ce=1 addr=20",
                     bus.rom_ce_o, bus.rom_addr_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL rmid_async: got %h expected %h", outs(), 100'h0);
        end
        tick();
        rst = 1'b1;
        drive_idle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.d_ack_o, bus.rom_ce_o} !== 2'b00) begin
                failures++;
                $display("FAIL rmid_noack k=%0d: got ack=%b ce=%b expected 0 0",
                         k, bus.d_ack_o, bus.rom_ce_o);
            end
            tick();
        end
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h44;
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h88;
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o} !== {1'b1, 32'h44}) begin
            failures++;
            $display("FAIL rmid_tie: got ce=%b addr=%h expected ce=1 addr=44",
                     bus.rom_ce_o, bus.rom_addr_o);
        end
        tick();
        checks++;
        if ({bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o} !== {1'b1, 32'h88, 1'b1}) begin
            failures++;
            $display("FAIL rmid_tie2: got ce=%b addr=%h iack=%b expected 1 88 1",
                     bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o);
        end
        bus.i_req_i = 1'b0;
        tick();
        checks++;
        if ({bus.d_ack_o, bus.d_rdata_o} !== {1'b1, rom_fn(32'h88)}) begin
            failures++;
            $display("FAIL rmid_dack: got ack=%b data=%h expected 1 %h",
                     bus.d_ack_o, bus.d_rdata_o, rom_fn(32'h88));
        end
        drive_idle();
    endtask

    //------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic        e_ce, e_ack;
        logic [31:0] ea;
        int          k;
        apply_reset();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h100;
        for (int c = 1; c <= 9; c++) begin
            tick();
            k    = (c - 1) / 2;
            if (k > 3) k = 3;
            ea   = 32'(32'h100 + 4 * k);
            e_ce = (c % 2 == 1) && (c <= 7);
            checks++;
            if ({bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o} !== {e_ce, ea, 1'b0}) begin
                failures++;
                $display("FAIL b2b_slot c=%0d: got ce=%b addr=%h iack=%b expected ce=%b addr=%h iack=0",
                         c, bus.rom_ce_o, bus.rom_addr_o, bus.i_ack_o, e_ce, ea);
            end
            e_ack = (c % 2 == 0) && (c <= 8);
            checks++;
            if (bus.d_ack_o !== e_ack) begin
                failures++;
                $display("FAIL b2b_ack c=%0d: got %b expected %b", c, bus.d_ack_o, e_ack);
            end
            if (e_ack) begin
                ea = 32'(32'h100 + 4 * ((c - 2) / 2));
                checks++;
                if (bus.d_rdata_o !== rom_fn(ea)) begin
                    failures++;
                    $display("FAIL b2b_data c=%0d: got %h expected %h", c, bus.d_rdata_o, rom_fn(ea));
                end
                if (c < 8) bus.d_addr_i = 32'(32'h100 + 4 * (c / 2));
                else       bus.d_req_i  = 1'b0;
            end
        end
    endtask

    //------------------------------------------------------------------------
    // Reference model: each grant schedules a ROM event one cycle later and
    // an ack event two cycles later, keyed by absolute cycle number.
    task automatic test_random();
        bit          ev_ce[int];
        logic [31:0] ev_addr[int];
        bit          ev_iack[int];
        logic [31:0] ev_idata[int];
        bit          ev_dack[int];
        logic [31:0] ev_ddata[int];
        bit          ev_derr[int];
        logic [31:0] m_rom_addr = '0, m_irdata = '0, m_drdata = '0;
        logic [99:0] exp_v;
        bit          e_ce, e_iack, e_dack, e_derr;
        bit          i_wait = 0, d_wait = 0, i_gnt = 0, d_gnt = 0;
        logic [31:0] i_a = '0, d_a = '0;
        bit          last_d = 1;
        int          gi = -10, gd = -10;
        bit          ei, ed, win_d, err;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            e_ce = ev_ce.exists(c);
            if (e_ce) m_rom_addr = ev_addr[c];
            e_iack = ev_iack.exists(c);
            if (e_iack) m_irdata = ev_idata[c];
            e_dack = ev_dack.exists(c);
            e_derr = 1'b0;
            if (e_dack) begin
                m_drdata = ev_ddata[c];
                e_derr   = ev_derr[c];
            end
            exp_v = {e_ce, m_rom_addr, e_iack, m_irdata, e_dack, m_drdata, e_derr};
            checks++;
            if (outs() !== exp_v) begin
                failures++;
                $display("FAIL random c=%0d: got %h expected %h", c, outs(), exp_v);
            end

            if (e_iack) i_wait = 0;
            if (!i_wait) begin
                if ($urandom_range(0, 99) < 55) begin
                    i_wait = 1; i_gnt = 0;
                    i_a = $urandom & 32'h0007_FFFF;
                end
            end else if (!i_gnt && $urandom_range(0, 9) == 0) begin
                i_wait = 0;
            end
            if (e_dack) d_wait = 0;
            if (!d_wait) begin
                if ($urandom_range(0, 99) < 55) begin
                    d_wait = 1; d_gnt = 0;
                    d_a = $urandom;
                    if ($urandom_range(0, 3) != 0) d_a = d_a & 32'h0007_FFFF;
                end
            end else if (!d_gnt && $urandom_range(0, 9) == 0) begin
                d_wait = 0;
            end
            bus.i_req_i  = i_wait;
            bus.i_addr_i = i_wait ? i_a : $urandom;
            bus.d_req_i  = d_wait;
            bus.d_addr_i = d_wait ? d_a : $urandom;

            ei = i_wait && (gi != c - 1);
            ed = d_wait && (gd != c - 1);
            if (ei || ed) begin
                win_d  = (ei && ed) ? !last_d : ed;
                last_d = win_d;
                if (win_d) begin
                    gd = c; d_gnt = 1;
                    err = (d_a >> (ROM_WORDS_LOG2 + 2)) != 0;
                    if (!err) begin
                        ev_ce[c+1]   = 1;
                        ev_addr[c+1] = d_a;
                    end
                    ev_dack[c+2]  = 1;
                    ev_ddata[c+2] = err ? 32'h0 : rom_fn(d_a);
                    ev_derr[c+2]  = err;
                end else begin
                    gi = c; i_gnt = 1;
                    ev_ce[c+1]    = 1;
                    ev_addr[c+1]  = i_a;
                    ev_iack[c+2]  = 1;
                    ev_idata[c+2] = rom_fn(i_a);
                end
            end
            tick();
        end
        drive_idle();
    endtask

    //------------------------------------------------------------------------
    initial begin
        rst   = 1'b1;
        noise = '0;
        drive_idle();
        test_reset();
        test_single_fetch();
        test_tie();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
